// File: rtl/p1_pkg.sv
// Shared types and default sizing for the decimal output stage.
package p1_pkg;

   localparam int P1_WIDTH  = 32;
   localparam int P1_DIGITS = 10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CONVERT = 3'd1,
      ST_SKIP    = 3'd2,
      ST_EMIT    = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

endpackage

// File: rtl/p1_dec_out_if.sv
// Bus between the solver result, the decimal converter and the digit consumer.
interface p1_dec_out_if #(
   parameter int WIDTH = 32
);
   // Handshake: a digit moves on a rising edge where DigitValid & Ready are both 1;
   // while Ready is 0, Digit/DigitLast/DigitValid stay frozen. Valid is a level, not a pulse.
   logic             Valid;
   logic [WIDTH-1:0] Value;
   logic             Ready;
   logic             DigitValid;
   logic [3:0]       Digit;
   logic             DigitLast;
   logic             Busy;
   logic             Done;

   modport master (
      output Valid, Value, Ready,
      input  DigitValid, Digit, DigitLast, Busy, Done
   );

   modport slave (
      input  Valid, Value, Ready,
      output DigitValid, Digit, DigitLast, Busy, Done
   );
endinterface

// File: rtl/p1_dec_out_bcd_add3.sv
// Double-dabble correction for one BCD digit: values 5..9 get +3 before the shift.
module bcd_add3 (
   input  logic [3:0] d,
   output logic [3:0] q
);
   assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/p1_dec_out.sv
// Converts a binary result to decimal via shift-add, then streams the digits
// most significant first with leading zeros suppressed.
module p1_dec_out
   import p1_pkg::*;
#(
   parameter int WIDTH  = P1_WIDTH,
   parameter int DIGITS = P1_DIGITS
) (
   input  logic            CLK,
   input  logic            Init,
   p1_dec_out_if.slave     bus,
   output state_t          dbg_state
);
   localparam int BW    = 4 * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int REM_W = $clog2(DIGITS + 1);

   state_t             state;
   logic [WIDTH-1:0]   sh;
   logic [BW-1:0]      bcd;
   logic [BW-1:0]      adj;
   logic [CNT_W-1:0]   cnt;
   logic [REM_W-1:0]   rem;
   logic               dv_q, last_q, busy_q, done_q;
   logic [3:0]         digit_q;
   logic [3:0]         top_dig;
   logic [3:0]         next_dig;

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (.d(bcd[4*g +: 4]), .q(adj[4*g +: 4]));
   end

   assign top_dig  = bcd[BW-1 -: 4];
   assign next_dig = bcd[BW-5 -: 4];

   always_ff @(posedge CLK) begin
      if (Init) begin
         state   <= ST_IDLE;
         sh      <= '0;
         bcd     <= '0;
         cnt     <= '0;
         rem     <= '0;
         dv_q    <= 1'b0;
         digit_q <= 4'd0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.Valid) begin
                  sh     <= bus.Value;
                  bcd    <= '0;
                  cnt    <= CNT_W'(WIDTH);
                  rem    <= REM_W'(DIGITS);
                  busy_q <= 1'b1;
                  state  <= ST_CONVERT;
               end
            end
            ST_CONVERT: begin
               // The corrected digits and the binary MSB shift as one wide register.
               bcd <= BW'({adj, sh[WIDTH-1]});
               sh  <= {sh[WIDTH-2:0], 1'b0};
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) state <= ST_SKIP;
            end
            ST_SKIP: begin
               if (bcd == '0) begin
                  // A zero result collapses straight to a single '0' digit.
                  rem     <= REM_W'(1);
                  dv_q    <= 1'b1;
                  digit_q <= 4'd0;
                  last_q  <= 1'b1;
                  state   <= ST_EMIT;
               end else if (top_dig == 4'd0 && rem > REM_W'(1)) begin
                  bcd <= {bcd[BW-5:0], 4'd0};
                  rem <= rem - 1'b1;
               end else begin
                  dv_q    <= 1'b1;
                  digit_q <= top_dig;
                  last_q  <= (rem == REM_W'(1));
                  state   <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (bus.Ready) begin
                  if (last_q) begin
                     dv_q    <= 1'b0;
                     digit_q <= 4'd0;
                     last_q  <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     bcd     <= '0;
                     rem     <= '0;
                     state   <= ST_DONE;
                  end else begin
                     bcd     <= {bcd[BW-5:0], 4'd0};
                     rem     <= rem - 1'b1;
                     digit_q <= next_dig;
                     last_q  <= (rem == REM_W'(2));
                  end
               end
            end
            ST_DONE: begin
               // Wait for the level to drop so one held Valid yields one conversion.
               if (!bus.Valid) begin
                  done_q <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.DigitValid = dv_q;
   assign bus.Digit      = digit_q;
   assign bus.DigitLast  = last_q;
   assign bus.Busy       = busy_q;
   assign bus.Done       = done_q;
   assign dbg_state      = state;

endmodule

// File: tb/tb_p1_dec_out.sv
// Directed bench for p1_dec_out: digit tables with hand-computed decimal strings
// and first-digit latencies, plus reset and Valid-level sequences.
module tb_p1_dec_out;
   import p1_pkg::*;

   localparam int W = 32;
   localparam int D = 10;

   logic   CLK = 1'b0;
   logic   Init = 1'b1;
   state_t dbg_state;

   p1_dec_out_if #(.WIDTH(W)) bus ();

   p1_dec_out #(.WIDTH(W), .DIGITS(D)) dut (
      .CLK       (CLK),
      .Init      (Init),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;
   logic [3:0] exp_q[$];

   typedef struct {
      logic [31:0] value;
      int          ndig;
      logic [39:0] digs;   // expected digits as nibbles, MSD at nibble ndig-1
      int          lat;    // edges counted from the capture edge (inclusive) to first DigitValid
      bit          stall;
      bit          wiggle;
   } vec_t;

   vec_t vecs[7];
   vec_t v1000;
   vec_t v7;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int         cnt;
      int         got;
      bit         r;
      bit         prev_stall;
      logic [3:0] prev_d;
      logic       prev_last;
      logic [3:0] d;
      exp_q.delete();
      for (int i = v.ndig - 1; i >= 0; i--) exp_q.push_back(v.digs[4*i +: 4]);
      @(negedge CLK);
      bus.Value = v.value;
      bus.Valid = 1'b1;
      bus.Ready = 1'b0;
      cnt = 0;
      while (1) begin
         @(posedge CLK);
         cnt++;
         #1;
         if (cnt == 1) check("busy_after_capture", bus.Busy, 1);
         if (bus.DigitValid || cnt > 200) break;
         if (v.wiggle && cnt < 10) begin
            bus.Valid = cnt[0];
            bus.Value = $urandom;
         end else begin
            bus.Valid = 1'b1;
         end
      end
      check("first_dv_latency", cnt, v.lat);
      if (!bus.DigitValid) return;
      prev_stall = 1'b0;
      prev_d     = 4'd0;
      prev_last  = 1'b0;
      got        = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge CLK);
         check("dv_held", bus.DigitValid, 1);
         if (!bus.DigitValid) break;
         if (prev_stall) begin
            check("stall_digit", bus.Digit, prev_d);
            check("stall_last", bus.DigitLast, prev_last);
         end
         if (!v.stall) r = 1'b1;
         else if (k == 1 || k == 2) r = 1'b0;
         else r = ($urandom_range(0, 1) == 1);
         bus.Ready = r;
         if (r) begin
            d = exp_q.pop_front();
            got++;
            check("digit", bus.Digit, d);
            check("digit_last", bus.DigitLast, exp_q.size() == 0);
            if (exp_q.size() == 0) begin
               @(posedge CLK);
               #1;
               check("done_after_last", bus.Done, 1);
               check("dv_after_last", bus.DigitValid, 0);
               check("busy_after_last", bus.Busy, 0);
               check("digit_zero_after_last", bus.Digit, 0);
               bus.Ready = 1'b0;
               break;
            end
         end
         prev_stall = !r;
         prev_d     = bus.Digit;
         prev_last  = bus.DigitLast;
      end
      check("digit_count", got, v.ndig);
   endtask

   initial begin
      bus.Valid = 1'b0;
      bus.Value = '0;
      bus.Ready = 1'b0;
      Init      = 1'b1;

      vecs[0] = '{32'd233168,     6,  40'h233168,     38, 1'b0, 1'b0};
      vecs[1] = '{32'd0,          1,  40'h0,          34, 1'b0, 1'b0};
      vecs[2] = '{32'hFFFF_FFFF,  10, 40'h4294967295, 34, 1'b0, 1'b0};
      vecs[3] = '{32'd233168,     6,  40'h233168,     38, 1'b1, 1'b0};
      vecs[4] = '{32'd1000,       4,  40'h1000,       40, 1'b0, 1'b1};
      vecs[5] = '{32'd10,         2,  40'h10,         42, 1'b1, 1'b0};
      vecs[6] = '{32'd1000000000, 10, 40'h1000000000, 34, 1'b1, 1'b1};
      v1000   = '{32'd1000,       4,  40'h1000,       40, 1'b0, 1'b0};
      v7      = '{32'd7,          1,  40'h7,          43, 1'b0, 1'b0};

      repeat (3) @(posedge CLK);
      #1;
      check("rst_dv", bus.DigitValid, 0);
      check("rst_digit", bus.Digit, 0);
      check("rst_last", bus.DigitLast, 0);
      check("rst_busy", bus.Busy, 0);
      check("rst_done", bus.Done, 0);
      check("rst_state", dbg_state, ST_IDLE);
      @(negedge CLK);
      Init = 1'b0;

      for (int i = 0; i < 7; i++) begin
         @(negedge CLK);
         bus.Valid = 1'b0;
         @(negedge CLK);
         run_vec(vecs[i]);
      end

      // Valid still high from the last vector: DONE must not restart.
      for (int i = 0; i < 100; i++) begin
         @(posedge CLK);
         #1;
         check("hold_no_dv", bus.DigitValid, 0);
         check("hold_done", bus.Done, 1);
      end
      @(negedge CLK);
      bus.Valid = 1'b0;
      @(posedge CLK);
      #1;
      check("done_to_idle", dbg_state, ST_IDLE);
      check("done_cleared", bus.Done, 0);
      run_vec(v7);

      // Init during CONVERT with Valid held high.
      @(negedge CLK);
      bus.Valid = 1'b0;
      @(negedge CLK);
      bus.Value = 32'd12345;
      bus.Valid = 1'b1;
      bus.Ready = 1'b0;
      repeat (10) @(posedge CLK);
      @(negedge CLK);
      Init = 1'b1;
      @(posedge CLK);
      #1;
      check("init_conv_state", dbg_state, ST_IDLE);
      check("init_conv_busy", bus.Busy, 0);
      check("init_conv_dv", bus.DigitValid, 0);
      @(negedge CLK);
      Init = 1'b0;
      @(posedge CLK);
      #1;
      check("recapture_state", dbg_state, ST_CONVERT);
      for (int k = 0; k < 100; k++) begin
         if (bus.DigitValid) break;
         @(posedge CLK);
         #1;
      end
      check("emit_reached", bus.DigitValid, 1);
      check("emit_first_digit", bus.Digit, 1);
      repeat (3) @(posedge CLK);
      #1;
      check("emit_stall_digit", bus.Digit, 1);

      // Init during EMIT wins over Ready in the same cycle.
      @(negedge CLK);
      Init      = 1'b1;
      bus.Ready = 1'b1;
      @(posedge CLK);
      #1;
      check("init_emit_state", dbg_state, ST_IDLE);
      check("init_emit_dv", bus.DigitValid, 0);
      check("init_emit_last", bus.DigitLast, 0);
      check("init_emit_digit", bus.Digit, 0);
      check("init_emit_done", bus.Done, 0);
      @(negedge CLK);
      Init      = 1'b0;
      bus.Valid = 1'b0;
      bus.Ready = 1'b0;
      run_vec(v1000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
